// File: rtl/mem_arbiter.sv
// Two-client arbiter for the single main-memory line port: the data cache wins
// ties, and a starvation counter lets the instruction cache through after a few losses.
module mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int CACHE_LINE_SIZE = 128,
    parameter int STARVE_LIMIT    = 2
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       ic_req,
    input  logic [ADDR_WIDTH-1:0]      ic_addr,
    output logic                       ic_ready,
    output logic [CACHE_LINE_SIZE-1:0] ic_read_data,

    input  logic                       dc_req,
    input  logic                       dc_we,
    input  logic [ADDR_WIDTH-1:0]      dc_addr,
    input  logic [CACHE_LINE_SIZE-1:0] dc_write_data,
    output logic                       dc_ready,
    output logic [CACHE_LINE_SIZE-1:0] dc_read_data,

    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [CACHE_LINE_SIZE-1:0] mem_write_data,
    input  logic                       mem_ready,
    input  logic [CACHE_LINE_SIZE-1:0] mem_read_data,

    output logic [1:0]                 owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IC = 2'd1,
        BUSY_DC = 2'd2,
        RESP    = 2'd3
    } state_e;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_IC   = 2'b01;
    localparam logic [1:0] OWNER_DC   = 2'b10;

    // The counter never exceeds STARVE_LIMIT: a tie at the limit resets it.
    localparam int              CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           starve_q, starve_d;
    logic                       mem_req_q, mem_req_d;
    logic                       mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]      mem_addr_q, mem_addr_d;
    logic [CACHE_LINE_SIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]                 owner_q, owner_d;
    logic                       ic_ready_q, ic_ready_d;
    logic                       dc_ready_q, dc_ready_d;
    logic [CACHE_LINE_SIZE-1:0] ic_rdata_q, ic_rdata_d;
    logic [CACHE_LINE_SIZE-1:0] dc_rdata_q, dc_rdata_d;
    logic                       grant_ic;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        owner_d     = owner_q;
        ic_ready_d  = 1'b0;
        dc_ready_d  = 1'b0;
        ic_rdata_d  = ic_rdata_q;
        dc_rdata_d  = dc_rdata_q;
        grant_ic    = ic_req && (!dc_req || (starve_q >= LIMIT));

        case (state_q)
            IDLE: begin
                if (grant_ic) begin
                    state_d     = BUSY_IC;
                    starve_d    = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = ic_addr;
                    mem_wdata_d = '0;
                    owner_d     = OWNER_IC;
                end else if (dc_req) begin
                    state_d     = BUSY_DC;
                    // Only a tie counts as an icache loss.
                    if (ic_req) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                    mem_req_d   = 1'b1;
                    mem_we_d    = dc_we;
                    mem_addr_d  = dc_addr;
                    mem_wdata_d = dc_write_data;
                    owner_d     = OWNER_DC;
                end
            end
            BUSY_IC: begin
                if (mem_ready) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    ic_rdata_d = mem_read_data;
                    ic_ready_d = 1'b1;
                end
            end
            BUSY_DC: begin
                if (mem_ready) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    if (!mem_we_q) begin
                        dc_rdata_d = mem_read_data;
                    end
                    dc_ready_d = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                owner_d = OWNER_NONE;
            end
            default: begin
                state_d = IDLE;
                owner_d = OWNER_NONE;
            end
        endcase
    end

    // NOTE: the read-data registers are reset too, because both buses must read 0 while in reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            owner_q     <= OWNER_NONE;
            ic_ready_q  <= 1'b0;
            dc_ready_q  <= 1'b0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            owner_q     <= owner_d;
            ic_ready_q  <= ic_ready_d;
            dc_ready_q  <= dc_ready_d;
            ic_rdata_q  <= ic_rdata_d;
            dc_rdata_q  <= dc_rdata_d;
        end
    end

    assign ic_ready       = ic_ready_q;
    assign ic_read_data   = ic_rdata_q;
    assign dc_ready       = dc_ready_q;
    assign dc_read_data   = dc_rdata_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign owner          = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of the grant rule and the memory handshake.
module tb_mem_arbiter;

    localparam int AW    = 32;
    localparam int LW    = 128;
    localparam int LIMIT = 2;
    localparam int WIN_IC = 1;
    localparam int WIN_DC = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ic_req = 1'b0;
    logic [AW-1:0] ic_addr = '0;
    logic          ic_ready;
    logic [LW-1:0] ic_read_data;
    logic          dc_req = 1'b0;
    logic          dc_we = 1'b0;
    logic [AW-1:0] dc_addr = '0;
    logic [LW-1:0] dc_write_data = '0;
    logic          dc_ready;
    logic [LW-1:0] dc_read_data;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [LW-1:0] mem_write_data;
    logic          mem_ready = 1'b0;
    logic [LW-1:0] mem_read_data = '0;
    logic [1:0]    owner;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            starve = 0;
    logic [LW-1:0] exp_ic_rdata = '0;
    logic [LW-1:0] exp_dc_rdata = '0;
    int            win;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_WIDTH(AW),
        .CACHE_LINE_SIZE(LW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ic_req(ic_req),
        .ic_addr(ic_addr),
        .ic_ready(ic_ready),
        .ic_read_data(ic_read_data),
        .dc_req(dc_req),
        .dc_we(dc_we),
        .dc_addr(dc_addr),
        .dc_write_data(dc_write_data),
        .dc_ready(dc_ready),
        .dc_read_data(dc_read_data),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_write_data(mem_write_data),
        .mem_ready(mem_ready),
        .mem_read_data(mem_read_data),
        .owner(owner)
    );

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".mem_req"},  LW'(mem_req),  '0);
        check({tag, ".owner"},    LW'(owner),    '0);
        check({tag, ".ic_ready"}, LW'(ic_ready), '0);
        check({tag, ".dc_ready"}, LW'(dc_ready), '0);
        check({tag, ".ic_rdata"}, ic_read_data,  exp_ic_rdata);
        check({tag, ".dc_rdata"}, dc_read_data,  exp_dc_rdata);
    endtask

    // Called at the falling edge of an IDLE cycle with at least one request driven.
    // Returns at the falling edge of the IDLE cycle that follows the ready pulse.
    task automatic run_txn(input string tag, input int lat, input logic [LW-1:0] rdata,
                           input bit hold, output int winner);
        logic [AW-1:0] e_addr;
        logic          e_we;
        logic [LW-1:0] e_wdata;
        if (dc_req && ic_req) begin
            if (starve >= LIMIT) begin
                winner = WIN_IC;
                starve = 0;
            end else begin
                winner = WIN_DC;
                starve = starve + 1;
            end
        end else if (dc_req) begin
            winner = WIN_DC;
        end else begin
            winner = WIN_IC;
            starve = 0;
        end
        e_addr  = (winner == WIN_IC) ? ic_addr : dc_addr;
        e_we    = (winner == WIN_IC) ? 1'b0 : dc_we;
        e_wdata = (winner == WIN_IC) ? '0 : dc_write_data;

        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check({tag, ".busy.mem_req"},  LW'(mem_req), LW'(1));
            check({tag, ".busy.owner"},    LW'(owner), LW'(winner));
            check({tag, ".busy.mem_addr"}, LW'(mem_addr), LW'(e_addr));
            check({tag, ".busy.mem_we"},   LW'(mem_we), LW'(e_we));
            check({tag, ".busy.wdata"},    mem_write_data, e_wdata);
            check({tag, ".busy.ready"},    LW'({ic_ready, dc_ready}), '0);
            mem_ready     = (k == lat);
            mem_read_data = (k == lat) ? rdata : rand_line();
        end

        @(negedge clk);
        if (winner == WIN_IC) exp_ic_rdata = rdata;
        else if (!e_we)       exp_dc_rdata = rdata;
        check({tag, ".resp.mem_req"},  LW'(mem_req), '0);
        check({tag, ".resp.owner"},    LW'(owner), LW'(winner));
        check({tag, ".resp.ic_ready"}, LW'(ic_ready), LW'(winner == WIN_IC));
        check({tag, ".resp.dc_ready"}, LW'(dc_ready), LW'(winner == WIN_DC));
        check({tag, ".resp.ic_rdata"}, ic_read_data, exp_ic_rdata);
        check({tag, ".resp.dc_rdata"}, dc_read_data, exp_dc_rdata);
        // A stray completion during the response cycle must be ignored.
        mem_ready     = 1'($urandom_range(0, 1));
        mem_read_data = rand_line();
        if (!hold) begin
            if (winner == WIN_IC) ic_req = 1'b0;
            else                  dc_req = 1'b0;
        end

        @(negedge clk);
        check_quiet({tag, ".idle"});
        mem_ready = 1'b0;
    endtask

    initial begin
        logic [LW-1:0] line;

        // Power-on reset
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        check("reset.mem_addr", LW'(mem_addr), '0);
        check("reset.mem_we",   LW'(mem_we), '0);
        check("reset.wdata",    mem_write_data, '0);
        reset = 1'b1;
        @(negedge clk);
        check_quiet("post_reset");

        // Spurious completion while idle
        mem_ready     = 1'b1;
        mem_read_data = rand_line();
        @(negedge clk);
        check_quiet("spurious_idle");
        mem_ready = 1'b0;

        // Single icache read with memory latency 5
        ic_req  = 1'b1;
        ic_addr = 32'h0000_1000;
        line    = 128'h00110013_00201083_00308113_00408193;
        run_txn("ic_read", 5, line, 1'b0, win);

        // Dcache writeback leaves dc_read_data untouched
        dc_req        = 1'b1;
        dc_we         = 1'b1;
        dc_addr       = 32'h0000_2000;
        dc_write_data = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        run_txn("dc_wb", 3, rand_line(), 1'b0, win);

        // Both clients re-requesting continuously: DC, DC, IC, DC, DC, IC
        ic_req  = 1'b1;
        ic_addr = 32'h0000_3000;
        dc_req  = 1'b1;
        dc_we   = 1'b0;
        dc_addr = 32'h0000_4000;
        for (int i = 0; i < 6; i++) begin
            run_txn("starve", 1 + (i % 3), rand_line(), 1'b1, win);
        end
        ic_req = 1'b0;
        dc_req = 1'b0;
        @(negedge clk);
        check_quiet("starve.drain");

        // Icache alone with req held: one idle cycle then a second grant
        ic_req  = 1'b1;
        ic_addr = 32'h0000_5000;
        run_txn("ic_held0", 2, rand_line(), 1'b1, win);
        run_txn("ic_held1", 1, rand_line(), 1'b0, win);

        // Leave the starvation counter at 1, then reset in the middle of a dcache read
        ic_req  = 1'b1;
        dc_req  = 1'b1;
        dc_addr = 32'h0000_6000;
        run_txn("pre_rst", 1, rand_line(), 1'b0, win);
        ic_req  = 1'b0;
        dc_req  = 1'b1;
        dc_we   = 1'b0;
        dc_addr = 32'h0000_0100;
        @(negedge clk);
        check("rst_mid.busy.mem_req", LW'(mem_req), LW'(1));
        check("rst_mid.busy.owner",   LW'(owner), LW'(WIN_DC));
        @(negedge clk);
        reset = 1'b0;
        #1;
        starve       = 0;
        exp_ic_rdata = '0;
        exp_dc_rdata = '0;
        check_quiet("rst_mid");
        @(negedge clk);
        reset = 1'b1;
        run_txn("rst_regrant", 2, rand_line(), 1'b0, win);

        // Counter was cleared by reset: expect DC, DC, IC again
        ic_req  = 1'b1;
        dc_req  = 1'b1;
        ic_addr = 32'h0000_7000;
        dc_addr = 32'h0000_8000;
        for (int i = 0; i < 3; i++) begin
            run_txn("post_rst_tie", 1, rand_line(), 1'b1, win);
        end
        ic_req = 1'b0;
        dc_req = 1'b0;
        @(negedge clk);
        check_quiet("post_rst.drain");

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            if (!ic_req && ($urandom_range(0, 1) == 1)) begin
                ic_req  = 1'b1;
                ic_addr = {$urandom} & 32'hFFFF_FFF0;
            end
            if (!dc_req && ($urandom_range(0, 1) == 1)) begin
                dc_req        = 1'b1;
                dc_we         = 1'($urandom_range(0, 1));
                dc_addr       = {$urandom} & 32'hFFFF_FFF0;
                dc_write_data = rand_line();
            end
            if (!ic_req && !dc_req) begin
                mem_ready     = 1'($urandom_range(0, 1));
                mem_read_data = rand_line();
                @(negedge clk);
                check_quiet("rand.idle");
                mem_ready = 1'b0;
            end else begin
                run_txn("rand", int'($urandom_range(1, 4)), rand_line(),
                        ($urandom_range(0, 3) == 0), win);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
